// File: rtl/addr_map_engine.sv
// addr_map_engine: two-table cuckoo-hash address map (GET/PUT/REMOVE) with bounded eviction,
// one displacement per cycle. Define ADDR_MAP_STATS_EN to add kick_total / fail_total counters.
module addr_map_engine #(
  parameter int unsigned           ADDR_WIDTH     = 64,
  parameter int unsigned           LG_NUM_BUCKETS = 4,
  parameter int unsigned           MAX_KICKS      = 8,
  parameter logic [ADDR_WIDTH-1:0] COE_A0         = 64'h9E3779B97F4A7C15,
  parameter logic [ADDR_WIDTH-1:0] COE_B0         = 64'h0,
  parameter logic [ADDR_WIDTH-1:0] COE_A1         = 64'hC2B2AE3D27D4EB4F,
  parameter logic [ADDR_WIDTH-1:0] COE_B1         = 64'h165667B19E3779F9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [ADDR_WIDTH-1:0]     req_key,
  input  logic [ADDR_WIDTH-1:0]     req_value,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [1:0]                rsp_status,
  output logic [ADDR_WIDTH-1:0]     rsp_value,
  output logic [ADDR_WIDTH-1:0]     rsp_key,
`ifdef ADDR_MAP_STATS_EN
  output logic [15:0]               kick_total,
  output logic [15:0]               fail_total,
`endif
  output logic [LG_NUM_BUCKETS+1:0] size
);

  localparam int unsigned NUM_BUCKETS = 1 << LG_NUM_BUCKETS;
  localparam int unsigned KW          = $clog2(MAX_KICKS + 2);

  typedef logic [LG_NUM_BUCKETS-1:0] idx_t;
  typedef logic [ADDR_WIDTH-1:0]     word_t;
  typedef logic [LG_NUM_BUCKETS+1:0] cnt_t;
  typedef logic [KW-1:0]             kicks_t;

  typedef enum logic [1:0] {IDLE, LOOKUP, KICK, RESP} state_t;
  typedef enum logic [1:0] {OP_GET, OP_PUT, OP_REMOVE, OP_RSVD} op_t;
  typedef enum logic [1:0] {ST_OK, ST_NOT_FOUND, ST_FAIL, ST_BAD_OP} status_t;

  function automatic idx_t hash(input word_t a, input word_t b, input word_t k);
    word_t p;
    p = a * k + b;
    return idx_t'(p >> (ADDR_WIDTH - LG_NUM_BUCKETS));
  endfunction

  // Tables
  logic  tv   [2][NUM_BUCKETS];
  word_t tkey [2][NUM_BUCKETS];
  word_t tval [2][NUM_BUCKETS];

  // State and datapath registers
  state_t  state_q, state_d;
  op_t     op_q, op_d;
  word_t   key_q, key_d, val_q, val_d;
  word_t   ck_q, ck_d, cv_q, cv_d;
  logic    tgt_q, tgt_d;
  kicks_t  kicks_q, kicks_d;
  status_t st_q, st_d;
  word_t   rv_q, rv_d, rk_q, rk_d;
  cnt_t    size_q, size_d;

  // Single table write port
  logic  wr_en, wr_tbl, wr_vld;
  idx_t  wr_idx;
  word_t wr_key, wr_val;

  // Lookup / kick probes
  idx_t  h0, h1, kidx, hit_idx;
  logic  hit0, hit1, hit_tbl, kocc, kick_last;
  word_t hit_val;

  always_comb begin
    h0        = hash(COE_A0, COE_B0, key_q);
    h1        = hash(COE_A1, COE_B1, key_q);
    kidx      = tgt_q ? hash(COE_A1, COE_B1, ck_q) : hash(COE_A0, COE_B0, ck_q);
    hit0      = tv[0][h0] && (tkey[0][h0] == key_q);
    hit1      = tv[1][h1] && (tkey[1][h1] == key_q);
    hit_tbl   = !hit0;
    hit_idx   = hit0 ? h0 : h1;
    hit_val   = hit0 ? tval[0][h0] : tval[1][h1];
    kocc      = tv[tgt_q][kidx];
    kick_last = (kicks_q + kicks_t'(1)) >= kicks_t'(MAX_KICKS);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    key_d   = key_q;
    val_d   = val_q;
    ck_d    = ck_q;
    cv_d    = cv_q;
    tgt_d   = tgt_q;
    kicks_d = kicks_q;
    st_d    = st_q;
    rv_d    = rv_q;
    rk_d    = rk_q;
    size_d  = size_q;
    wr_en   = 1'b0;
    wr_tbl  = 1'b0;
    wr_vld  = 1'b0;
    wr_idx  = '0;
    wr_key  = key_q;
    wr_val  = val_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = op_t'(req_op);
          key_d   = req_key;
          val_d   = req_value;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        state_d = RESP;
        st_d    = ST_OK;
        rv_d    = '0;
        rk_d    = key_q;
        unique case (op_q)
          OP_GET: begin
            if (hit0 || hit1) rv_d = hit_val;
            else              st_d = ST_NOT_FOUND;
          end
          OP_REMOVE: begin
            if (hit0 || hit1) begin
              wr_en  = 1'b1;
              wr_tbl = hit_tbl;
              wr_idx = hit_idx;
              wr_vld = 1'b0;
              wr_val = hit_val;
              rv_d   = hit_val;
              size_d = size_q - cnt_t'(1);
            end else begin
              st_d = ST_NOT_FOUND;
            end
          end
          OP_PUT: begin
            wr_en  = 1'b1;
            wr_vld = 1'b1;
            if (hit0 || hit1) begin
              wr_tbl = hit_tbl;
              wr_idx = hit_idx;
              rv_d   = hit_val;
            end else if (!tv[0][h0]) begin
              wr_idx = h0;
              size_d = size_q + cnt_t'(1);
            end else if (!tv[1][h1]) begin
              wr_tbl = 1'b1;
              wr_idx = h1;
              size_d = size_q + cnt_t'(1);
            end else begin
              // New key takes table 0; its previous occupant is carried into KICK.
              wr_idx  = h0;
              ck_d    = tkey[0][h0];
              cv_d    = tval[0][h0];
              tgt_d   = 1'b1;
              kicks_d = kicks_t'(1);
              size_d  = size_q + cnt_t'(1);
              state_d = KICK;
            end
          end
          OP_RSVD: st_d = ST_BAD_OP;
        endcase
      end
      KICK: begin
        wr_en  = 1'b1;
        wr_tbl = tgt_q;
        wr_idx = kidx;
        wr_vld = 1'b1;
        wr_key = ck_q;
        wr_val = cv_q;
        rv_d   = '0;
        rk_d   = key_q;
        if (!kocc) begin
          st_d    = ST_OK;
          state_d = RESP;
        end else begin
          ck_d    = tkey[tgt_q][kidx];
          cv_d    = tval[tgt_q][kidx];
          tgt_d   = !tgt_q;
          kicks_d = kicks_q + kicks_t'(1);
          if (kick_last) begin
            st_d    = ST_FAIL;
            rk_d    = tkey[tgt_q][kidx];
            size_d  = size_q - cnt_t'(1);
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_GET;
      key_q   <= '0;
      val_q   <= '0;
      ck_q    <= '0;
      cv_q    <= '0;
      tgt_q   <= 1'b0;
      kicks_q <= '0;
      st_q    <= ST_OK;
      rv_q    <= '0;
      rk_q    <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      key_q   <= key_d;
      val_q   <= val_d;
      ck_q    <= ck_d;
      cv_q    <= cv_d;
      tgt_q   <= tgt_d;
      kicks_q <= kicks_d;
      st_q    <= st_d;
      rv_q    <= rv_d;
      rk_q    <= rk_d;
      size_q  <= size_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned t = 0; t < 2; t++)
        for (int unsigned b = 0; b < NUM_BUCKETS; b++)
          tv[t][b] <= 1'b0;
    end else if (wr_en) begin
      tv[wr_tbl][wr_idx] <= wr_vld;
    end
  end

  // Key/value storage is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tkey[wr_tbl][wr_idx] <= wr_key;
      tval[wr_tbl][wr_idx] <= wr_val;
    end
  end

`ifdef ADDR_MAP_STATS_EN
  logic kick_evt, fail_evt;

  always_comb begin
    kick_evt = ((state_q == LOOKUP) && (op_q == OP_PUT) && !hit0 && !hit1 && tv[0][h0] && tv[1][h1])
            || ((state_q == KICK) && kocc);
    fail_evt = (state_q == KICK) && kocc && kick_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kick_total <= '0;
      fail_total <= '0;
    end else begin
      if (kick_evt && (kick_total != '1)) kick_total <= kick_total + 16'd1;
      if (fail_evt && (fail_total != '1)) fail_total <= fail_total + 16'd1;
    end
  end
`endif

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_status = st_q;
  assign rsp_value  = rv_q;
  assign rsp_key    = rk_q;
  assign size       = size_q;

endmodule
